// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative RV64M multiply/divide unit in the EX stage. An M-extension op
// presented by the ID/EX register is accepted in IDLE. It runs one radix-2
// step per cycle for XLEN cycles in CALC. The signed result is then
// registered out of DONE as a one-cycle valid_o pulse. While the op is being
// accepted and while it is in CALC, stall_o freezes PC, IF/ID and ID/EX.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, a zero divisor (any op) or a zero multiplicand (MUL family)
//   preloads the final raw result and skips the iterations. CALC then lasts a
//   single cycle. Results are identical to the full run.
//
// Ports
//   clk        in   1     clock, rising edge
//   reset      in   1     synchronous, active-high reset
//   start_i    in   1     ID/EX holds an M-extension op
//   flush_i    in   1     kill the in-flight op
//   funct3_i   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                         100 DIV,101 DIVU,110 REM,111 REMU
//   rs1_val_i  in   XLEN  operand a
//   rs2_val_i  in   XLEN  operand b
//   rd_i       in   5     destination register
//   stall_o    out  1     freeze PC, IF/ID and ID/EX this cycle
//   busy_o     out  1     unit is not idle
//   valid_o    out  1     result_o/rd_o valid this cycle (1-cycle pulse)
//   result_o   out  XLEN  result
//   rd_o       out  5     destination register of result
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state, state_next;
  logic              accept;

  // Operation context captured at accept.
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              a_neg, b_neg, b_zero;
  logic [CNT_W-1:0]  counter;

  // opnd holds |a| (multiplicand) for MUL ops or |b| (divisor) for DIV ops.
  // acc is the 2*XLEN product for MUL ops. For DIV ops it is
  // {remainder, dividend/quotient}: quotient bits shift in from the bottom
  // while dividend bits shift out of the top of the low half.
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  // ---------------------------------------------------------------------
  // Operand preparation at accept
  // ---------------------------------------------------------------------
  logic              is_mul_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] acc_full_init;
  logic [2*XLEN-1:0] acc_init;
  logic [CNT_W-1:0]  cnt_init;
  logic              step_en;

  assign is_mul_in = ~funct3_i[2];
  // Operand a is signed for MULH, MULHSU, DIV and REM. Operand b is signed
  // for MULH, DIV and REM.
  assign a_sgn_in  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign b_sgn_in  = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                     (funct3_i == 3'b110);
  assign a_neg_in  = a_sgn_in & rs1_val_i[XLEN-1];
  assign b_neg_in  = b_sgn_in & rs2_val_i[XLEN-1];
  assign a_abs     = a_neg_in ? -rs1_val_i : rs1_val_i;
  assign b_abs     = b_neg_in ? -rs2_val_i : rs2_val_i;
  assign acc_full_init = is_mul_in ? {{XLEN{1'b0}}, b_abs} : {{XLEN{1'b0}}, a_abs};

`ifdef MULDIV_EARLY_OUT_EN
  logic early, early_in;
  assign early_in = (rs2_val_i == '0) || (is_mul_in && (rs1_val_i == '0));
  // The preloaded values are exactly what the full iteration would leave in
  // acc: a zero product, or quotient all-ones with the remainder equal to |a|.
  assign acc_init = !early_in  ? acc_full_init :
                    is_mul_in  ? {2*XLEN{1'b0}} :
                                 {a_abs, {XLEN{1'b1}}};
  assign cnt_init = early_in ? '0 : CNT_LAST;
  assign step_en  = ~early;

  always_ff @(posedge clk) begin
    if (reset)       early <= 1'b0;
    else if (accept) early <= early_in;
  end
`else
  assign acc_init = acc_full_init;
  assign cnt_init = CNT_LAST;
  assign step_en  = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Radix-2 step logic
  // ---------------------------------------------------------------------
  logic            is_mul;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff, div_rem;
  logic            div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign is_mul    = ~funct3_q[2];
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  // Restoring divide: bring down the next dividend bit, then subtract the
  // divisor if it fits. The difference always fits XLEN bits when it is used.
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[XLEN-1:0] - opnd;
  assign div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc[XLEN-2:0], div_ge};

  // ---------------------------------------------------------------------
  // Sign fixup and result select
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result_sel;
  logic              q_neg;

  assign prod  = (a_neg ^ b_neg) ? -acc : acc;
  // A zero divisor leaves the quotient all-ones regardless of sign. The
  // remainder keeps the dividend sign, which turns |a| back into a.
  assign q_neg = (a_neg ^ b_neg) & ~b_zero;
  assign quo   = q_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem   = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    result_sel = rem;
    case (funct3_q)
      3'b000:                 result_sel = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_sel = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_sel = quo;
      default:                result_sel = rem;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    accept     = 1'b0;
    busy_o     = (state != IDLE);
    case (state)
      IDLE: begin
        // A simultaneous flush kills the op before it is accepted.
        if (start_i && !flush_i) begin
          accept     = 1'b1;
          stall_o    = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (flush_i)              state_next = IDLE;
        else if (counter == '0)   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (reset) begin
      funct3_q <= '0;
      rd_q     <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      counter  <= '0;
      opnd     <= '0;
      acc      <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        funct3_q <= funct3_i;
        rd_q     <= rd_i;
        a_neg    <= a_neg_in;
        b_neg    <= b_neg_in;
        b_zero   <= (rs2_val_i == '0);
        counter  <= cnt_init;
        opnd     <= is_mul_in ? a_abs : b_abs;
        acc      <= acc_init;
      end else if (state == CALC) begin
        if (step_en)        acc     <= is_mul ? mul_next : div_next;
        if (counter != '0)  counter <= counter - CNT_W'(1);
      end else if (state == DONE && !flush_i) begin
        valid_o  <= 1'b1;
        result_o <= result_sel;
        rd_o     <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Self-checking bench for ex_muldiv_unit (XLEN=64). Directed cases, then
// random ops with operands biased toward corner values. Every result is
// compared with a behavioural reference model built from 128-bit and
// signed 64-bit arithmetic. It also checks latency, stall length, rd, the
// one-cycle valid pulse, flush and reset behaviour. Latency expectations
// follow MULDIV_EARLY_OUT_EN when the bench is built with that macro.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [63:0] rs1_val_i, rs2_val_i;
  logic [4:0]  rd_i;
  logic        stall_o, busy_o, valid_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;
  logic prev_valid = 1'b0;

  ex_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .funct3_i  (funct3_i),
    .rs1_val_i (rs1_val_i),
    .rs2_val_i (rs2_val_i),
    .rd_i      (rd_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_o      (rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain wide/signed arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [63:0]  lo;
    longint       sa, sb;
    sa = a;
    sb = b;
    pa = {64'b0, a};
    pb = {64'b0, b};
    if (f3 == 3'b001 || f3 == 3'b010) pa = {{64{a[63]}}, a};
    if (f3 == 3'b001)                 pb = {{64{b[63]}}, b};
    p  = pa * pb;
    lo = a * b;
    case (f3)
      3'b000:                 return lo;
      3'b001, 3'b010, 3'b011: return p[127:64];
      3'b100: begin
        if (b == 64'd0) return '1;
        if (a == MIN64 && b == '1) return MIN64;
        return sa / sb;
      end
      3'b101:  return (b == 64'd0) ? '1 : a / b;
      3'b110: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == '1) return 64'd0;
        return sa % sb;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // Edges from the accepting edge until valid_o is visible.
  function automatic int exp_latency(input logic [2:0] f3, input logic [63:0] a,
                                     input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 64'd0 || (a == 64'd0 && !f3[2])) return 2;
`endif
    return 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return MIN64;
      3:       return 64'($urandom_range(0, 50));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // valid_o must never be high in two consecutive cycles.
  always @(negedge clk) begin
    if (valid_o) check("valid_consecutive", 64'(prev_valid), 64'd0);
    prev_valid = valid_o;
  end

  // One complete op. With hold set, start_i stays high while the unit stalls,
  // as a frozen ID/EX register would present it.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input logic hold);
    int n, stalls, lat;
    logic [63:0] exp;
    exp = ref_model(f3, a, b);
    lat = exp_latency(f3, a, b);
    @(negedge clk);
    funct3_i  = f3;
    rs1_val_i = a;
    rs2_val_i = b;
    rd_i      = rd;
    flush_i   = 1'b0;
    start_i   = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    @(negedge clk);
    n = 0;
    while (!valid_o && n < 200) begin
      if (stall_o) stalls++;
      start_i = hold && stall_o;
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_rd"}, 64'(rd_o), 64'(rd));
    @(negedge clk);
    check({tag, "_valid_pulse_end"}, 64'(valid_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    start_i   = 1'b0;
    flush_i   = 1'b0;
    funct3_i  = 3'b000;
    rs1_val_i = '0;
    rs2_val_i = '0;
    rd_i      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_valid",  64'(valid_o), 64'd0);
    check("reset_busy",   64'(busy_o),  64'd0);
    check("reset_stall",  64'(stall_o), 64'd0);
    check("reset_result", result_o,     64'd0);
    check("reset_rd",     64'(rd_o),    64'd0);

    // Directed results.
    do_op("mul_7_m3",     3'b000, 64'd7,   -64'sd3, 5'd7,  1'b0);
    do_op("mulhu_ones",   3'b011, '1,      '1,      5'd8,  1'b0);
    do_op("mulh_m1_m1",   3'b001, '1,      '1,      5'd9,  1'b1);
    do_op("mulhsu_neg",   3'b010, -64'sd5, '1,      5'd10, 1'b0);
    do_op("div_m20_3",    3'b100, -64'sd20, 64'd3,  5'd11, 1'b0);
    do_op("rem_m20_3",    3'b110, -64'sd20, 64'd3,  5'd12, 1'b1);
    do_op("divu_20_0",    3'b101, 64'd20,  64'd0,   5'd13, 1'b0);
    do_op("rem_m20_0",    3'b110, -64'sd20, 64'd0,  5'd14, 1'b0);
    do_op("div_ovf",      3'b100, MIN64,   '1,      5'd15, 1'b0);
    do_op("rem_ovf",      3'b110, MIN64,   '1,      5'd16, 1'b0);
    do_op("mulh_a_zero",  3'b001, 64'd0,   -64'sd9, 5'd17, 1'b0);
    do_op("div_m7_0",     3'b100, -64'sd7, 64'd0,   5'd18, 1'b0);

    // Flush and start in the same IDLE cycle: flush wins.
    @(negedge clk);
    funct3_i = 3'b000; rs1_val_i = 64'd3; rs2_val_i = 64'd4;
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_start_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    check("flush_start_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0; flush_i = 1'b0;

    // Flush at CALC cycle 10, then a new op two cycles later.
    @(negedge clk);
    funct3_i = 3'b100; rs1_val_i = 64'd1000; rs2_val_i = 64'd7; rd_i = 5'd20;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy",  64'(busy_o),  64'd0);
    check("flush_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    do_op("after_flush", 3'b000, 64'd123456789, 64'd987654321, 5'd21, 1'b0);

    // Reset at CALC cycle 30.
    @(negedge clk);
    funct3_i = 3'b011; rs1_val_i = '1; rs2_val_i = 64'd3; rd_i = 5'd22;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy",   64'(busy_o),  64'd0);
    check("midreset_valid",  64'(valid_o), 64'd0);
    check("midreset_result", result_o,     64'd0);
    do_op("after_reset", 3'b111, 64'd100, 64'd7, 5'd23, 1'b0);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [63:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
